// File: rtl/slt_serial.sv
// rtl/slt_serial.sv - bit-serial a-b compare unit producing SLT flags and the resolved less-than result.
module slt_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             unsigned_mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lt_o,
  output logic             sign_o,
  output logic             overflow_o,
  output logic             carry_o,
  output logic             zero_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_reg_q, carry_reg_d;
  logic             zero_acc_q, zero_acc_d;
  logic             mode_q, mode_d;
  logic             lt_q, lt_d;
  logic             sign_q, sign_d;
  logic             overflow_q, overflow_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic b_inv, diff_bit, carry_nxt, last_bit;

  // One full-subtractor step: a + ~b + carry, LSB first.
  always_comb begin
    b_inv     = ~b_sh_q[0];
    diff_bit  = a_sh_q[0] ^ b_inv ^ carry_reg_q;
    carry_nxt = (a_sh_q[0] & b_inv) | (a_sh_q[0] & carry_reg_q) | (b_inv & carry_reg_q);
    last_bit  = (count_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    count_d     = count_q;
    carry_reg_d = carry_reg_q;
    zero_acc_d  = zero_acc_q;
    mode_d      = mode_q;
    lt_d        = lt_q;
    sign_d      = sign_q;
    overflow_d  = overflow_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          a_sh_d      = a_i;
          b_sh_d      = b_i;
          mode_d      = unsigned_mode_i;
          carry_reg_d = 1'b1;
          zero_acc_d  = 1'b1;
          count_d     = '0;
          state_d     = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d      = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_reg_d = carry_nxt;
        zero_acc_d  = zero_acc_q & ~diff_bit;
        count_d     = count_q + CW'(1);
        // MSB step: carry_reg_q is the carry into the sign bit.
        if (last_bit) begin
          state_d    = S_DONE;
          sign_d     = diff_bit;
          carry_d    = carry_nxt;
          overflow_d = carry_reg_q ^ carry_nxt;
          zero_d     = zero_acc_q & ~diff_bit;
          lt_d       = mode_q ? ~carry_nxt : (diff_bit ^ (carry_reg_q ^ carry_nxt));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      count_q     <= '0;
      carry_reg_q <= 1'b0;
      zero_acc_q  <= 1'b0;
      mode_q      <= 1'b0;
      lt_q        <= 1'b0;
      sign_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      count_q     <= count_d;
      carry_reg_q <= carry_reg_d;
      zero_acc_q  <= zero_acc_d;
      mode_q      <= mode_d;
      lt_q        <= lt_d;
      sign_q      <= sign_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign busy_o     = (state_q == S_SHIFT);
  assign done_o     = (state_q == S_DONE);
  assign lt_o       = lt_q;
  assign sign_o     = sign_q;
  assign overflow_o = overflow_q;
  assign carry_o    = carry_q;
  assign zero_o     = zero_q;
endmodule
